// File: rtl/hsi_tx_frame_arb.sv
// N-channel HSI TX arbiter/framer: payload, CRC-16/CCITT, then inter-frame gap; one registered output stage that stalls on tx_rdy.
// Define HSI_TX_RR_EN for round-robin arbitration; otherwise fixed priority with index 0 highest.
module hsi_tx_frame_arb #(
  parameter int          N_CH      = 5,
  parameter int          GAP_TICKS = 4800,
  parameter int          GAP_W     = 13,
  parameter int          MAX_LEN   = 255,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [N_CH-1:0]   ch_req,
  input  logic [N_CH-1:0]   ch_reply,
  input  logic [8*N_CH-1:0] ch_d,
  input  logic [N_CH-1:0]   ch_d_vld,
  input  logic [N_CH-1:0]   ch_last,
  output logic [N_CH-1:0]   ch_grant,
  output logic [N_CH-1:0]   ch_d_ack,
  output logic [7:0]        tx_d,
  output logic              tx_d_vld,
  input  logic              tx_rdy,
  output logic              frame_end,
  output logic [N_CH-1:0]   reply_wait,
  output logic              len_err
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_TICKS > 0) ? GAP_W'(GAP_TICKS - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_CRC_HI, S_CRC_LO, S_TAIL, S_GAP
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  gidx_q;
  logic [N_CH-1:0]   grant_q;
  logic [15:0]       crc_q;
  logic [LEN_W-1:0]  len_q;
  logic [GAP_W-1:0]  gap_q;
  logic [7:0]        tx_d_q;
  logic              tx_vld_q;
  logic              frame_end_q;
  logic [N_CH-1:0]   reply_wait_q;
  logic              len_err_q;
`ifdef HSI_TX_RR_EN
  logic [IDX_W-1:0]  last_q;
`endif

  logic              can_load, xfer, take;
  logic              sel_vld, sel_last;
  logic [7:0]        sel_d;
  logic [15:0]       crc_d;
  logic [LEN_W-1:0]  len_d;
  logic              req_any;
  logic [IDX_W-1:0]  req_idx;
  logic [N_CH-1:0]   grant_d;

  // Bit-serial form of x^16 + x^12 + x^5 + 1, MSB first.
  function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ b[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  assign can_load = !tx_vld_q || tx_rdy;
  assign xfer     = tx_vld_q && tx_rdy;

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_d    = 8'h00;
    for (int i = 0; i < N_CH; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        sel_vld  = ch_d_vld[i];
        sel_last = ch_last[i];
        sel_d    = ch_d[8*i +: 8];
      end
    end
  end

  assign take     = (state_q == S_DATA) && sel_vld && can_load;
  assign ch_d_ack = take ? grant_q : '0;
  assign crc_d    = crc_fold(crc_q, sel_d);
  assign len_d    = len_q + 1'b1;

  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    grant_d = '0;
`ifdef HSI_TX_RR_EN
    for (int k = 0; k < N_CH; k++) begin
      int j;
      j = (int'(last_q) + 1 + k) % N_CH;
      if (!req_any && ch_req[j]) begin
        req_any = 1'b1;
        req_idx = IDX_W'(j);
      end
    end
`else
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (ch_req[k]) begin
        req_any = 1'b1;
        req_idx = IDX_W'(k);
      end
    end
`endif
    grant_d[req_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      gidx_q       <= '0;
      grant_q      <= '0;
      crc_q        <= CRC_INIT;
      len_q        <= '0;
      gap_q        <= '0;
      tx_d_q       <= 8'h00;
      tx_vld_q     <= 1'b0;
      frame_end_q  <= 1'b0;
      reply_wait_q <= '0;
      len_err_q    <= 1'b0;
`ifdef HSI_TX_RR_EN
      last_q       <= IDX_W'(N_CH - 1);
`endif
    end else begin
      frame_end_q <= 1'b0;
      // A transferred byte empties the stage unless a new byte loads below.
      if (xfer) tx_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            gidx_q  <= req_idx;
            grant_q <= grant_d;
            crc_q   <= CRC_INIT;
            len_q   <= '0;
            state_q <= S_DATA;
`ifdef HSI_TX_RR_EN
            last_q  <= req_idx;
`endif
          end
        end
        S_DATA: begin
          if (take) begin
            tx_d_q   <= sel_d;
            tx_vld_q <= 1'b1;
            crc_q    <= crc_d;
            len_q    <= len_d;
            if (sel_last) begin
              state_q <= S_CRC_HI;
            end else if (len_d == LEN_MAX) begin
              len_err_q <= 1'b1;
              state_q   <= S_CRC_HI;
            end
          end
        end
        S_CRC_HI: begin
          if (can_load) begin
            tx_d_q   <= crc_q[15:8];
            tx_vld_q <= 1'b1;
            state_q  <= S_CRC_LO;
          end
        end
        S_CRC_LO: begin
          if (can_load) begin
            tx_d_q   <= crc_q[7:0];
            tx_vld_q <= 1'b1;
            state_q  <= S_TAIL;
          end
        end
        S_TAIL: begin
          // Frame ends when the CRC low byte is actually accepted by the coder.
          if (xfer) begin
            frame_end_q <= 1'b1;
            grant_q     <= '0;
            if (GAP_TICKS == 0) begin
              state_q <= S_IDLE;
            end else begin
              state_q      <= S_GAP;
              reply_wait_q <= grant_q & ch_reply;
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q        <= '0;
            reply_wait_q <= '0;
            state_q      <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ch_grant   = grant_q;
  assign tx_d       = tx_d_q;
  assign tx_d_vld   = tx_vld_q;
  assign frame_end  = frame_end_q;
  assign reply_wait = reply_wait_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_hsi_tx_frame_arb.sv
// Bench for hsi_tx_frame_arb: scoreboarded byte stream on a 5-channel instance plus a 1-channel MAX_LEN=4 instance.
module tb_hsi_tx_frame_arb;
  localparam int GAP = 8;

  logic        clk, n_rst;
  logic [4:0]  ch_req, ch_reply, ch_d_vld, ch_last, ch_grant, ch_d_ack, reply_wait;
  logic [39:0] ch_d;
  logic [7:0]  tx_d;
  logic        tx_d_vld, tx_rdy, frame_end, len_err;

  logic        l_req, l_reply, l_d_vld, l_last, l_grant, l_d_ack, l_tx_d_vld, l_tx_rdy;
  logic        l_frame_end, l_reply_wait, l_len_err;
  logic [7:0]  l_d, l_tx_d;

  hsi_tx_frame_arb #(.N_CH(5), .GAP_TICKS(GAP), .GAP_W(4), .MAX_LEN(255), .CRC_INIT(16'hFFFF)) u_dut (
    .clk(clk), .n_rst(n_rst), .ch_req(ch_req), .ch_reply(ch_reply), .ch_d(ch_d),
    .ch_d_vld(ch_d_vld), .ch_last(ch_last), .ch_grant(ch_grant), .ch_d_ack(ch_d_ack),
    .tx_d(tx_d), .tx_d_vld(tx_d_vld), .tx_rdy(tx_rdy), .frame_end(frame_end),
    .reply_wait(reply_wait), .len_err(len_err));

  hsi_tx_frame_arb #(.N_CH(1), .GAP_TICKS(0), .GAP_W(1), .MAX_LEN(4), .CRC_INIT(16'hFFFF)) u_len (
    .clk(clk), .n_rst(n_rst), .ch_req(l_req), .ch_reply(l_reply), .ch_d(l_d),
    .ch_d_vld(l_d_vld), .ch_last(l_last), .ch_grant(l_grant), .ch_d_ack(l_d_ack),
    .tx_d(l_tx_d), .tx_d_vld(l_tx_d_vld), .tx_rdy(l_tx_rdy), .frame_end(l_frame_end),
    .reply_wait(l_reply_wait), .len_err(l_len_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sources 0..4 feed u_dut, source 5 feeds u_len.
  logic [7:0] src_mem [6][16];
  int         src_len [6];
  int         src_base[6];
  int         ack_tot [6];
  bit         src_last[6];
  logic [7:0] stg[16];

  logic [7:0] exp_q[$];
  logic [7:0] lexp_q[$];
  logic [4:0] glog[$];

  int  n_assert, n_fail;
  int  fe_cnt, l_fe_cnt, since_fe, gap_meas, rw_cnt;
  logic [4:0] rw_or, pg;
  logic       pv, pr, bp;
  logic [7:0] pd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {stg[i], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic push_frame(input int n, input bit to_len);
    logic [15:0] c;
    c = crc_model(n);
    for (int i = 0; i < n; i++) if (to_len) lexp_q.push_back(stg[i]); else exp_q.push_back(stg[i]);
    if (to_len) begin lexp_q.push_back(c[15:8]); lexp_q.push_back(c[7:0]); end
    else        begin exp_q.push_back(c[15:8]);  exp_q.push_back(c[7:0]);  end
  endtask

  task automatic drive();
    int pos; logic v, lst; logic [7:0] d;
    for (int c = 0; c < 6; c++) begin
      pos = ack_tot[c] - src_base[c];
      v   = (pos < src_len[c]);
      d   = v ? src_mem[c][pos] : 8'h00;
      lst = v && src_last[c] && (pos == src_len[c] - 1);
      if (c < 5) begin ch_d[8*c +: 8] = d; ch_d_vld[c] = v; ch_last[c] = lst; end
      else       begin l_d = d; l_d_vld = v; l_last = lst; end
    end
    ch_req = ch_req & ~ch_grant;
    l_req  = l_req & ~l_grant;
    tx_rdy = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
  endtask

  task automatic load_src(input int c, input int n, input bit last);
    src_base[c] = ack_tot[c];
    src_len[c]  = n;
    src_last[c] = last;
    for (int i = 0; i < n; i++) src_mem[c][i] = stg[i];
    drive();
  endtask

  task automatic sample();
    logic [8:0] e;
    for (int c = 0; c < 5; c++) if (ch_d_ack[c]) ack_tot[c]++;
    if (l_d_ack) ack_tot[5]++;
    if (pv && !pr) begin
      chk("hold_vld", tx_d_vld, 1);
      chk("hold_d", tx_d, pd);
    end
    if (tx_d_vld && tx_rdy) begin
      e = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
      chk("tx_d", tx_d, e);
    end
    pv = tx_d_vld; pr = tx_rdy; pd = tx_d;
    if (l_tx_d_vld && l_tx_rdy) begin
      e = (lexp_q.size() != 0) ? {1'b0, lexp_q.pop_front()} : 9'h100;
      chk("len_tx_d", l_tx_d, e);
    end
    if (frame_end) begin fe_cnt++; since_fe = 0; end else since_fe++;
    if (ch_grant != 0 && pg == 0) begin glog.push_back(ch_grant); gap_meas = since_fe; end
    pg = ch_grant;
    if (reply_wait != 0) begin rw_cnt++; rw_or = rw_or | reply_wait; end
    if (l_frame_end) l_fe_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    if (n_rst) sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_fe(input int target, input int budget);
    int k = 0;
    while (fe_cnt < target && k < budget) begin tick(); k++; end
    chk("frame_end_count", fe_cnt, target);
  endtask

  initial begin
    int tgt, gb, k;
    n_assert = 0; n_fail = 0; fe_cnt = 0; l_fe_cnt = 0; since_fe = 0; gap_meas = 0;
    rw_cnt = 0; rw_or = '0; pg = '0; pv = 0; pr = 0; pd = '0; bp = 0;
    for (int c = 0; c < 6; c++) begin src_len[c] = 0; src_base[c] = 0; ack_tot[c] = 0; src_last[c] = 0; end
    ch_req = '0; ch_reply = 5'b00100; l_req = 1'b0; l_reply = 1'b0; l_tx_rdy = 1'b1;
    ch_d = '0; ch_d_vld = '0; ch_last = '0; l_d = '0; l_d_vld = 0; l_last = 0; tx_rdy = 1'b1;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_d_vld", tx_d_vld, 0);
    chk("rst_tx_d", tx_d, 0);
    chk("rst_grant", ch_grant, 0);
    chk("rst_frame_end", frame_end, 0);
    chk("rst_reply_wait", reply_wait, 0);
    chk("rst_len_err", len_err, 0);
    n_rst = 1'b1;
    tick();

    // "123456789" on ch0, then ch1 requested during the gap.
    for (int i = 0; i < 9; i++) stg[i] = 8'h31 + 8'(i);
    load_src(0, 9, 1);
    for (int i = 0; i < 9; i++) exp_q.push_back(stg[i]);
    exp_q.push_back(8'h29); exp_q.push_back(8'hB1);
    stg[0] = 8'hA5; stg[1] = 8'h5A;
    load_src(1, 2, 1);
    push_frame(2, 0);
    ch_req = 5'b00001;
    wait_fe(1, 200);
    ch_req = 5'b00010;
    wait_fe(2, 200);
    chk("gap_to_next_grant", gap_meas, GAP + 1);
    repeat (GAP + 3) tick();
    chk("ch1_reply_wait_cycles", rw_cnt, 0);
    chk("t1_queue_drained", exp_q.size(), 0);
    chk("grant_0", (glog.size() > 0) ? glog[0] : 5'h1F, 5'b00001);
    chk("grant_1", (glog.size() > 1) ? glog[1] : 5'h1F, 5'b00010);

    // Simultaneous requests on ch2 (reply expected) and ch4.
    gb = glog.size();
    for (int i = 0; i < 3; i++) stg[i] = 8'($urandom);
    load_src(2, 3, 1); push_frame(3, 0);
    for (int i = 0; i < 2; i++) stg[i] = 8'($urandom);
    load_src(4, 2, 1); push_frame(2, 0);
    rw_cnt = 0; rw_or = '0;
    ch_req = 5'b10100;
    tgt = fe_cnt + 2;
    wait_fe(tgt, 400);
    repeat (GAP + 3) tick();
    chk("prio_first", (glog.size() > gb) ? glog[gb] : 5'h1F, 5'b00100);
    chk("prio_second", (glog.size() > gb + 1) ? glog[gb + 1] : 5'h1F, 5'b10000);
    chk("reply_wait_cycles", rw_cnt, GAP);
    chk("reply_wait_value", rw_or, 5'b00100);
    chk("t2_queue_drained", exp_q.size(), 0);

    // 4-byte frame on ch3 with 30% tx_rdy.
    for (int i = 0; i < 4; i++) stg[i] = 8'($urandom);
    bp = 1;
    load_src(3, 4, 1); push_frame(4, 0);
    ch_req = 5'b01000;
    tgt = fe_cnt + 1;
    wait_fe(tgt, 600);
    bp = 0;
    chk("bp_acks", ack_tot[3] - src_base[3], 4);
    chk("bp_queue_drained", exp_q.size(), 0);

    // MAX_LEN=4 instance, 6-byte source with no last.
    for (int i = 0; i < 6; i++) stg[i] = 8'($urandom);
    load_src(5, 6, 0); push_frame(4, 1);
    l_req = 1'b1;
    k = 0;
    while (l_fe_cnt < 1 && k < 200) begin tick(); k++; end
    chk("len_frame_end", l_fe_cnt, 1);
    repeat (10) tick();
    chk("len_acks", ack_tot[5] - src_base[5], 4);
    chk("len_queue_drained", lexp_q.size(), 0);
    chk("len_err_sticky", l_len_err, 1);
    chk("main_len_err", len_err, 0);

    // Reset in the middle of a ch0 payload.
    for (int i = 0; i < 8; i++) stg[i] = 8'($urandom);
    load_src(0, 8, 1); push_frame(8, 0);
    ch_req = 5'b00001;
    k = 0;
    while ((ack_tot[0] - src_base[0]) < 3 && k < 100) begin tick(); k++; end
    chk("mid_data_reached", ((ack_tot[0] - src_base[0]) >= 3) ? 1 : 0, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_tx_d_vld", tx_d_vld, 0);
    chk("arst_tx_d", tx_d, 0);
    chk("arst_grant", ch_grant, 0);
    chk("arst_ack", ch_d_ack, 0);
    chk("arst_frame_end", frame_end, 0);
    chk("arst_reply_wait", reply_wait, 0);
    chk("arst_len_err", l_len_err, 0);
    exp_q.delete();
    for (int c = 0; c < 6; c++) src_len[c] = 0;
    pv = 0; pg = '0;
    repeat (3) tick();
    n_rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) stg[i] = 8'($urandom);
    load_src(0, 4, 1); push_frame(4, 0);
    ch_req = 5'b00001;
    tgt = fe_cnt + 1;
    wait_fe(tgt, 200);
    repeat (GAP + 3) tick();
    chk("post_rst_acks", ack_tot[0] - src_base[0], 4);
    chk("post_rst_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/hsi_tx_frame_arb.md
Name: hsi_tx_frame_arb

Overview:
- N-channel transmit frame arbiter and framer for the HSI master link; generalises the fixed TM/BTC/SR/DPR/CCW TX controller.
- Grants one requesting source at a time and streams its payload bytes to the line coder.
- Appends a CRC-16/CCITT to every frame, then enforces a programmable inter-frame gap.
- Flags frames that expect a reply so the RX side can open its reply window.

Parameters:
- N_CH, 5, number of source channels (1..8); index 0 has the highest priority.
- GAP_TICKS, 4800, inter-frame gap in clk cycles (100 us at 48 MHz); 0 means no gap.
- GAP_W, 13, gap counter width; must satisfy 2^GAP_W > GAP_TICKS.
- MAX_LEN, 255, maximum payload bytes per frame.
- CRC_INIT, 16'hFFFF, CRC preset value.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- ch_req  in  N_CH  per-channel frame request (level)
- ch_reply  in  N_CH  static mask: channel expects a reply after its frame
- ch_d  in  8*N_CH  per-channel payload byte; channel i uses bits [8i+7:8i]
- ch_d_vld  in  N_CH  per-channel byte valid
- ch_last  in  N_CH  qualifies ch_d as the final payload byte
- ch_grant  out  N_CH  one-hot grant, held from frame start to frame end
- ch_d_ack  out  N_CH  one-cycle pulse when the granted channel's byte is taken
- tx_d  out  8  byte to the coder
- tx_d_vld  out  1  tx_d valid
- tx_rdy  in  1  coder accepts a byte
- frame_end  out  1  one-cycle pulse on CRC low byte accept
- reply_wait  out  N_CH  one-hot; high during GAP after a reply-expecting frame
- len_err  out  1  sticky overflow flag; cleared by reset only

Behaviour:
- Reset (async): state IDLE; all outputs 0; CRC = CRC_INIT; counters 0.
- Output stage is a valid/ready register. A byte transfers on a cycle where tx_d_vld=1 and tx_rdy=1.
- The stage loads when tx_d_vld=0 or tx_rdy=1. tx_d and tx_d_vld are held stable until the byte transfers.
- IDLE:
  - If any ch_req bit is set, grant the highest-priority requester (lowest index).
  - ch_grant is registered, so it goes high the cycle after IDLE sees the request.
  - Go to DATA and preset the CRC to CRC_INIT.
- DATA:
  - When ch_d_vld[g]=1 and the stage can load: load ch_d[g], pulse ch_d_ack[g], fold the byte into the CRC, and increment the length counter.
  - On ch_last[g] with the loaded byte, go to CRC_HI.
  - If the length counter reaches MAX_LEN without ch_last: set len_err and force CRC_HI. The source's remaining bytes are not acked.
- CRC:
  - Polynomial 0x1021, MSB-first, no reflection, no final XOR, computed over payload bytes only.
  - CRC_HI loads crc[15:8]. CRC_LO loads crc[7:0].
  - On CRC_LO transfer: pulse frame_end, drop ch_grant, and go to GAP. If GAP_TICKS=0, go directly to IDLE.
- GAP:
  - Counter runs 0..GAP_TICKS-1, then returns to IDLE.
  - reply_wait[g] is high throughout GAP when ch_reply[g]=1.
  - The gap counter is held in reset outside GAP.
- Request rules:
  - ch_req is sampled only in IDLE.
  - Deasserting ch_req mid-frame does not abort the frame.
  - Requests arriving during GAP wait for IDLE.
  - Simultaneous requests are resolved by priority.
- One full frame is at least 3 coder transfers (1 payload byte + 2 CRC bytes).
- Reset mid-frame aborts immediately. No partial-frame recovery is attempted.

Optional Feature:
- Macro: HSI_TX_RR_EN.
- When defined: round-robin arbitration. Search starts at index (last_granted+1) mod N_CH; last_granted resets to N_CH-1, so the first search starts at 0.
- When undefined: fixed priority, index 0 highest. No last_granted register exists.

Test Plan:
- Single channel 0 frame "123456789" (0x31..0x39), tx_rdy=1:
  - tx_d sequence is 0x31..0x39, 0x29, 0xB1.
  - frame_end pulses once.
  - GAP lasts GAP_TICKS cycles before the next grant.
- ch_req=5'b10100 asserted in the same cycle:
  - Fixed priority: ch2 frame completes, then ch4.
  - With HSI_TX_RR_EN and last_granted=2: ch4 is granted first.
- Backpressure: random tx_rdy at 30% duty on a 4-byte frame:
  - tx_d holds stable while tx_d_vld=1 and tx_rdy=0.
  - No byte is dropped or duplicated; CRC matches the model.
- MAX_LEN=4 with no ch_last on a 6-byte source:
  - Exactly 4 acks, then 2 CRC bytes.
  - len_err=1 until reset.
- ch_reply=5'b00100, frame on ch2:
  - reply_wait=5'b00100 for the whole GAP, 0 otherwise.
  - A frame on ch1 yields reply_wait=0.
- Assert n_rst low mid-DATA:
  - All outputs go to 0 asynchronously.
  - After release, the next frame's CRC starts from 0xFFFF.
